// File: rtl/muldiv_pkg.sv
// Shared op codes, default latencies and helpers for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned CNT_W           = 5;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MADD  = 3'b100;
  localparam logic [2:0] MD_MADDU = 3'b101;
  localparam logic [2:0] MD_MSUB  = 3'b110;
  localparam logic [2:0] MD_MSUBU = 3'b111;

  function automatic logic is_div(input logic [2:0] op);
    return (op[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Combinational datapath: 64-bit product, signed/unsigned divide and HI/LO accumulate.
module muldiv_core
  import muldiv_pkg::*;
(
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] r_hi,
  output logic [XLEN-1:0] r_lo,
  output logic            div0
);

  logic            sgn;
  logic            neg_q;
  logic            neg_r;
  logic [63:0]     ea;
  logic [63:0]     eb;
  logic [63:0]     prod;
  logic [63:0]     res;
  logic [XLEN-1:0] ma;
  logic [XLEN-1:0] mb;
  logic [XLEN-1:0] q;
  logic [XLEN-1:0] r;

  // Signed divide via magnitudes so INT_MIN / -1 wraps to INT_MIN without overflow traps.
  always_comb begin
    sgn   = ~op[0];
    ea    = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb    = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    prod  = ea * eb;
    ma    = (sgn && a[31]) ? -a : a;
    mb    = (sgn && b[31]) ? -b : b;
    div0  = (b == '0);
    q     = '0;
    r     = '0;
    if (!div0) begin
      q = ma / mb;
      r = ma % mb;
    end
    neg_q = sgn & (a[31] ^ b[31]);
    neg_r = sgn & a[31];
    case (op)
      MD_DIV, MD_DIVU:   res = {(neg_r ? -r : r), (neg_q ? -q : q)};
      MD_MADD, MD_MADDU: res = {hi, lo} + prod;
      MD_MSUB, MD_MSUBU: res = {hi, lo} - prod;
      default:           res = prod;
    endcase
    r_hi = res[63:32];
    r_lo = res[31:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit with fixed-latency busy window and mthi/mtlo writes.
// Define MULDIV_MADD_EN to enable madd/maddu/msub/msubu (op codes 100-111).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  p_hi;
  logic [XLEN-1:0]  p_lo;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic             div0;
  logic             legal;

`ifdef MULDIV_MADD_EN
  assign legal = 1'b1;
`else
  assign legal = ~op[2];
`endif

  muldiv_core u_core (
    .op   (op),
    .a    (a),
    .b    (b),
    .hi   (hi),
    .lo   (lo),
    .r_hi (r_hi),
    .r_lo (r_lo),
    .div0 (div0)
  );

  // Divide by zero parks the current HI/LO as the pending result so commit is a no-op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (legal) begin
              p_hi  <= (is_div(op) && div0) ? hi : r_hi;
              p_lo  <= (is_div(op) && div0) ? lo : r_lo;
              cnt   <= is_div(op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
              busy  <= 1'b1;
              state <= RUN;
            end
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            hi    <= p_hi;
            lo    <= p_lo;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multiply/divide responder for the five-stage MIPS pipeline: accepts a one-cycle `start` pulse from the EX stage with two 32-bit operands, holds `busy` for a fixed latency, then commits the result into the architectural HI/LO registers. It also services `mthi`/`mtlo` writes and continuously drives `hi`/`lo` for `mfhi`/`mflo`. The pipeline hazard unit stalls ID on `start || busy` when the instruction in ID touches HI/LO.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult-class ops, legal range 1..31.
- `DIV_CYCLES`, default 10: busy cycles for div-class ops, legal range 1..31.

Ports:
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `start`  in  1: one-cycle request; `op`, `a`, `b` are sampled with it.
- `op`  in  3: 000 mult, 001 multu, 010 div, 011 divu, 100 madd, 101 maddu, 110 msub, 111 msubu.
- `a`  in  32: rs operand (dividend / multiplicand).
- `b`  in  32: rt operand (divisor / multiplier).
- `mthi`  in  1: write `wdata` to HI.
- `mtlo`  in  1: write `wdata` to LO.
- `wdata`  in  32: mthi/mtlo data.
- `busy`  out  1: operation in flight.
- `hi`  out  32: HI register.
- `lo`  out  32: LO register.

## Operation
- Two-state FSM: IDLE, RUN. 5-bit down-counter `cnt`. Pending result registers `p_hi`, `p_lo`.
- IDLE and `start` with a legal op: compute result from `a`, `b`, `op` (and current `hi`/`lo` for madd/msub), latch it into `p_hi`/`p_lo`, load `cnt` = latency-1, go to RUN.
- RUN: decrement `cnt` each edge; at the edge where `cnt`==0, copy `p_hi`/`p_lo` to `hi`/`lo` and return to IDLE.
- mult/multu: {hi,lo} = a*b as 64-bit signed/unsigned product.
- div/divu: lo = quotient, hi = remainder, signed truncating toward zero, so the remainder takes the sign of the dividend. Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Division by zero: full DIV_CYCLES busy; hi/lo are left unchanged at commit.
- madd/msub: {hi,lo} = {hi,lo} +/- a*b, using hi/lo as they stand at the start edge. The 64-bit add wraps modulo 2^64.
- `start` while in RUN: ignored. The pipeline guarantees this does not occur.
- `mthi`/`mtlo` in IDLE with no `start`: the write lands at the next edge. Both may be asserted together.
- `mthi`/`mtlo` during RUN, or in the same cycle as `start`: ignored.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, FSM=IDLE, `cnt`=0, `p_hi`=`p_lo`=0. Reset asserted mid-RUN aborts the operation; no commit occurs.
- `start` sampled at edge T: `busy`=1 from just after T through edge T+N, where N = MULT_CYCLES or DIV_CYCLES.
- Commit: `hi`/`lo` take the new value at edge T+N, and `busy` falls at that same edge.
- A new `start` is accepted at edge T+N+1 at the earliest.
- `busy` is a registered output. `hi`/`lo` change only at commit, on an mthi/mtlo write, or on reset.

## Configuration
- `MULDIV_MADD_EN` defined: op codes 100–111 (madd/maddu/msub/msubu) are implemented with MULT_CYCLES latency.
- `MULDIV_MADD_EN` undefined: any `start` with `op[2]`=1 is ignored. FSM stays IDLE, `busy` stays 0, hi/lo are unchanged.

## Structure
- Shared package `muldiv_pkg`:
  - op-code localparams `MD_MULT` … `MD_MSUBU`;
  - the default latency constants;
  - helper `is_div(op)`.
- One sub-module `muldiv_core`: purely combinational. Takes `op`, `a`, `b`, `hi`, `lo`; outputs a 64-bit `{r_hi, r_lo}` and a `div0` flag.
- Top level holds the FSM, counter, pending registers and HI/LO.

## Test plan
- **mult:** a=0xFFFFFFFF, b=2, op=mult → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Same operands with multu → hi=0x00000001, lo=0xFFFFFFFE.
- **div:** a=-7 (0xFFFFFFF9), b=2, op=div → busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu 7/2 → lo=3, hi=1.
- **div by zero:** mthi 0x11, mtlo 0x22, then div with b=0 → busy 10 cycles; hi=0x11, lo=0x22 afterwards.
- **mthi/mtlo while busy:** mtlo 0x1234 asserted during RUN of a multu 3*4 → ignored; after commit lo=12. mtlo in IDLE → lo=0x1234 next edge.
- **reset mid-operation:** start div, assert reset at cycle 4 → busy, hi, lo all 0 immediately; after deassert, a new mult starts normally.
- **madd (with `MULDIV_MADD_EN`):** hi=0, lo=0xFFFFFFFF, then madd a=1, b=1 → hi=1, lo=0 after 5 cycles. Without the macro the same stimulus leaves busy=0 and hi/lo unchanged.
